// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller and its prefetch FIFO.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_controller_fifo.sv
// Prefetch FIFO: synchronous push/pop with flush; head entry is readable without a pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, drives instruction memory and feeds decode through a prefetch FIFO.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted,
  output logic               fetch_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = INSTR_W + ADDR_W;

  fetch_state_e         state;
  logic [ADDR_W-1:0]    pc;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENT_W-1:0]     fifo_head;
  logic                 redirect_take;
  logic                 fifo_full;
  logic                 pop;
  logic                 fetch;

  // Once a fault has been latched every redirect is ignored; only reset recovers.
  always_comb begin
    redirect_take = redirect_valid && !fetch_err;
    fifo_full     = (fifo_count == CNT_W'(FIFO_DEPTH));
    out_valid     = (fifo_count != '0) && !redirect_take;
    pop           = out_valid && out_ready;
    fetch         = (state == ST_RUN) && !redirect_take && !halt_req && (!fifo_full || pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
    end else if (redirect_take) begin
      if (is_word_aligned(redirect_pc[1:0])) begin
        pc     <= redirect_pc;
        state  <= ST_RUN;
        halted <= 1'b0;
      end else begin
        state     <= ST_HALT;
        halted    <= 1'b1;
        fetch_err <= 1'b1;
      end
    end else begin
      unique case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (fetch) begin
            pc <= pc + ADDR_W'(4);
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fetch),
    .push_data ({imem_instr, pc}),
    .pop       (pop),
    .flush     (redirect_take),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign imem_addr = pc;
  assign out_instr = fifo_head[ENT_W-1:ADDR_W];
  assign out_pc    = fifo_head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, randomized run against a queue model, PC wrap/reset.
module tb_fetch_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT 1: default RESET_PC
  logic        rst_n, out_ready, redirect_valid, halt_req;
  logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, halted, fetch_err;

  assign imem_instr = {imem_addr[31:2], 2'b11};

  fetch_controller #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(halted), .fetch_err(fetch_err)
  );

  // DUT 2: RESET_PC near the top of the address space
  logic        rst2_n = 1'b0;
  logic [31:0] imem_addr2, imem_instr2, out_instr2, out_pc2;
  logic        out_valid2, halted2, fetch_err2;

  assign imem_instr2 = {imem_addr2[31:2], 2'b11};

  fetch_controller #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2), .out_pc(out_pc2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halt_req(1'b0),
    .halted(halted2), .fetch_err(fetch_err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11};
  endfunction

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        eh;
    logic        ee;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic h, input logic ev, input logic [31:0] epc,
                              input logic [31:0] ea, input logic eh, input logic ee);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.redir = rv; v.rpc = rpc; v.halt = h;
    v.ev = ev; v.epc = epc; v.eaddr = ea; v.eh = eh; v.ee = ee;
    return v;
  endfunction

  // Reference model state
  logic [31:0] m_pc;
  int          m_st;  // 0 boot, 1 run, 2 halt
  logic        m_err;
  logic [31:0] m_q[$];
  localparam int M_DEPTH = 2;

  task automatic model_step();
    bit take, pop, fetch;
    if (!rst_n) begin
      m_pc = 32'h0; m_st = 0; m_err = 1'b0; m_q.delete();
      return;
    end
    take = redirect_valid && !m_err;
    if (take) begin
      m_q.delete();
      if (redirect_pc % 4 == 0) begin
        m_pc = redirect_pc; m_st = 1;
      end else begin
        m_st = 2; m_err = 1'b1;
      end
      return;
    end
    pop   = (m_q.size() > 0) && out_ready;
    fetch = (m_st == 1) && !halt_req && ((m_q.size() < M_DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (fetch) begin
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (m_st == 0) m_st = 1;
    else if (m_st == 1 && halt_req) m_st = 2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vq[$];
    bit   model_ok;
    bit   exp_v;

    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_out_pc", out_pc, 32'h0);
    check("reset_out_instr", out_instr, 32'h0);
    check("reset_imem_addr", imem_addr, 32'h0);
    check("reset_halted", {31'b0, halted}, 32'h0);
    check("reset_fetch_err", {31'b0, fetch_err}, 32'h0);

    //            rst  rdy  rv   rpc           halt ev   epc           eaddr         eh   ee
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 0));  // BOOT
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 0));  // first fetch
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 1, 32'h0,  32'h4,  0, 0));  // valid in 3rd cycle
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 1, 32'h4,  32'h8,  0, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 1, 32'h8,  32'hC,  0, 0));  // stall
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 1, 32'h8,  32'h10, 0, 0));  // full, pc frozen
    vq.push_back(mk(1, 1, 1, 32'h24, 0, 0, 32'h0,  32'h10, 0, 0));  // redirect flushes
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h24, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 1, 32'h24, 32'h28, 0, 0));  // target 2 cycles later
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 1, 32'h28, 32'h2C, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h28, 32'h30, 0, 0));  // halt with 2 entries
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 1, 32'h2C, 32'h30, 1, 0));  // draining in HALT
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h30, 1, 0));
    vq.push_back(mk(1, 1, 1, 32'h40, 0, 0, 32'h0,  32'h30, 1, 0));  // resume
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h40, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 1, 32'h40, 32'h44, 0, 0));
    vq.push_back(mk(1, 1, 1, 32'h26, 0, 0, 32'h0,  32'h48, 0, 0));  // misaligned
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h48, 1, 1));
    vq.push_back(mk(1, 1, 1, 32'h0,  0, 0, 32'h0,  32'h48, 1, 1));  // ignored after fault
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h48, 1, 1));
    vq.push_back(mk(0, 1, 0, 32'h0,  0, 0, 32'h0,  32'h48, 1, 1));  // sync reset
    vq.push_back(mk(1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n = vq[i].rst; out_ready = vq[i].rdy; redirect_valid = vq[i].redir;
      redirect_pc = vq[i].rpc; halt_req = vq[i].halt;
      #1;
      check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vq[i].ev});
      check($sformatf("vec%0d_imem_addr", i), imem_addr, vq[i].eaddr);
      check($sformatf("vec%0d_halted", i), {31'b0, halted}, {31'b0, vq[i].eh});
      check($sformatf("vec%0d_fetch_err", i), {31'b0, fetch_err}, {31'b0, vq[i].ee});
      if (vq[i].ev) begin
        check($sformatf("vec%0d_out_pc", i), out_pc, vq[i].epc);
        check($sformatf("vec%0d_out_instr", i), out_instr, mem_word(vq[i].epc));
      end
    end

    // Randomized run against the queue model
    model_ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n          = (n == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      halt_req       = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 4) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      #1;
      if (model_ok) begin
        exp_v = (m_q.size() != 0) && !(redirect_valid && !m_err);
        check("rnd_out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        check("rnd_imem_addr", imem_addr, m_pc);
        check("rnd_halted", {31'b0, halted}, {31'b0, (m_st == 2)});
        check("rnd_fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
        if (exp_v) begin
          check("rnd_out_pc", out_pc, m_q[0]);
          check("rnd_out_instr", out_instr, mem_word(m_q[0]));
        end
      end
      @(posedge clk);
      model_step();
      if (!rst_n) model_ok = 1'b1;
    end

    // PC wrap on the second instance, then a mid-stream reset
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("wrap_valid0", {31'b0, out_valid2}, 32'h1);
    check("wrap_pc0", out_pc2, 32'hFFFF_FFF8);
    check("wrap_instr0", out_instr2, mem_word(32'hFFFF_FFF8));
    @(negedge clk); #1;
    check("wrap_valid1", {31'b0, out_valid2}, 32'h1);
    check("wrap_pc1", out_pc2, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap_valid2", {31'b0, out_valid2}, 32'h1);
    check("wrap_pc2", out_pc2, 32'h0000_0000);
    check("wrap_err", {31'b0, fetch_err2}, 32'h0);
    rst2_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_valid", {31'b0, out_valid2}, 32'h0);
    check("midrst_imem_addr", imem_addr2, 32'hFFFF_FFF8);
    check("midrst_halted", {31'b0, halted2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
